fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions.
// Reset PC, bubble word, fetch FSM encoding, IF/ID bundle.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Flush and empty cycles load a bubble; stall holds.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output if_id_t      ifId
);

  localparam if_id_t BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      32'd0,
    pcPlus4: 32'd0,
    valid:   1'b0
  };

  // flush wins over everything; load never coincides with stall
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ifId <= BUBBLE;
    end else if (load) begin
      ifId <= '{
        instr:   instr,
        pc:      pc,
        pcPlus4: pc + 32'd4,
        valid:   1'b1
      };
    end else if (!stall) begin
      ifId <= BUBBLE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with single-outstanding imem port.
// FETCH issues, WAIT collects, HOLD parks a word under stall.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] holdBuf;
  logic [31:0] holdNext;
  logic        kill;
  logic        killNext;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic [31:0] target;
  if_id_t      ifId;

  assign target = {redirect_pc[31:2], 2'b00};
  assign imem_req = (state == FETCH) && !reset;
  assign imem_addr = pc;

  // next-state, pc, kill and hold-buffer decisions
  always_comb begin
    stateNext = state;
    pcNext = pc;
    killNext = kill;
    holdNext = holdBuf;
    deliver = 1'b0;
    deliverInstr = imem_rdata;
    unique case (1'b1)
      (state == FETCH): begin
        stateNext = WAIT;
        if (redirect_valid) begin
          pcNext = target;
          killNext = 1'b1;
        end
      end
      (state == WAIT): begin
        if (redirect_valid) begin
          pcNext = target;
          if (imem_rvalid) begin
            stateNext = FETCH;
            killNext = 1'b0;
          end else begin
            killNext = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            stateNext = FETCH;
            killNext = 1'b0;
          end else if (!stall_f) begin
            deliver = 1'b1;
            pcNext = pc + 32'd4;
            stateNext = FETCH;
          end else begin
            holdNext = imem_rdata;
            stateNext = HOLD;
          end
        end
      end
      (state == HOLD): begin
        deliverInstr = holdBuf;
        if (redirect_valid) begin
          pcNext = target;
          holdNext = NOP_INSTR;
          stateNext = FETCH;
        end else if (!stall_f) begin
          deliver = 1'b1;
          pcNext = pc + 32'd4;
          holdNext = NOP_INSTR;
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // fetch state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      kill <= 1'b0;
      holdBuf <= NOP_INSTR;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      kill <= killNext;
      holdBuf <= holdNext;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifId (
    .clk  (clk),
    .reset(reset),
    .stall(stall_f),
    .flush(flush_d | redirect_valid),
    .load (deliver),
    .instr(deliverInstr),
    .pc   (pc),
    .ifId (ifId)
  );

  assign instr_d = ifId.instr;
  assign pc_d = ifId.pc;
  assign pcplus4_d = ifId.pcPlus4;
  assign valid_d = ifId.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Inputs and checks at negedge; imem model with set latency.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_f;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  int tests = 0;
  int fails = 0;

  int          memLat = 1;
  int          cnt = 0;
  bit          pend = 0;
  logic        reqPrev = 1'b0;
  logic [31:0] addrPrev = '0;
  logic [31:0] pAddr = '0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_f       (stall_f),
    .flush_d       (flush_d),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pcplus4_d     (pcplus4_d),
    .valid_d       (valid_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instrOf(
    input logic [31:0] a
  );
    return 32'hC0DE_0000 ^ a;
  endfunction

  // sample the request mid-cycle, after stimulus settles
  always @(negedge clk) begin
    #1;
    reqPrev = imem_req;
    addrPrev = imem_addr;
  end

  // memory ignores reset so stale responses reach the DUT
  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (reqPrev) begin
      pend = 1;
      cnt = memLat;
      pAddr = addrPrev;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = instrOf(pAddr);
        pend = 0;
      end
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    stall_f = 1'b0;
    flush_d = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;

    repeat (2) cyc();
    check("rst_req", {31'd0, imem_req}, 0);
    check("rst_valid", {31'd0, valid_d}, 0);
    check("rst_instr", instr_d, 32'h13);
    check("rst_pc", pc_d, 0);

    cyc(); // c0
    reset = 1'b0;
    #1;
    check("c0_req", {31'd0, imem_req}, 1);
    check("c0_addr", imem_addr, 32'h0);

    cyc(); // c1
    check("c1_req", {31'd0, imem_req}, 0);

    cyc(); // c2
    check("c2_req", {31'd0, imem_req}, 1);
    check("c2_addr", imem_addr, 32'h4);
    check("c2_valid", {31'd0, valid_d}, 1);
    check("c2_pc", pc_d, 32'h0);
    check("c2_pc4", pcplus4_d, 32'h4);
    check("c2_instr", instr_d, instrOf(32'h0));

    cyc(); // c3
    check("c3_valid", {31'd0, valid_d}, 0);
    check("c3_req", {31'd0, imem_req}, 0);

    cyc(); // c4
    check("c4_addr", imem_addr, 32'h8);
    check("c4_valid", {31'd0, valid_d}, 1);
    check("c4_pc", pc_d, 32'h4);
    stall_f = 1'b1;

    for (int i = 5; i <= 7; i++) begin
      cyc();
      check("stall_valid", {31'd0, valid_d}, 1);
      check("stall_pc", pc_d, 32'h4);
      check("stall_req", {31'd0, imem_req}, 0);
    end
    stall_f = 1'b0;

    cyc(); // c8
    check("c8_valid", {31'd0, valid_d}, 1);
    check("c8_pc", pc_d, 32'h8);
    check("c8_instr", instr_d, instrOf(32'h8));
    check("c8_addr", imem_addr, 32'hC);
    memLat = 2;

    cyc(); // c9
    check("c9_once", {31'd0, valid_d}, 0);
    check("c9_req", {31'd0, imem_req}, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;

    cyc(); // c10
    check("c10_valid", {31'd0, valid_d}, 0);
    check("c10_req", {31'd0, imem_req}, 0);
    redirect_valid = 1'b0;
    memLat = 1;

    cyc(); // c11
    check("c11_req", {31'd0, imem_req}, 1);
    check("c11_addr", imem_addr, 32'h100);
    check("c11_novalid", {31'd0, valid_d}, 0);

    cyc(); // c12
    check("c12_valid", {31'd0, valid_d}, 0);

    cyc(); // c13
    check("c13_addr", imem_addr, 32'h104);
    check("c13_pc", pc_d, 32'h100);
    check("c13_pc4", pcplus4_d, 32'h104);
    check("c13_instr", instr_d, instrOf(32'h100));
    stall_f = 1'b1;
    flush_d = 1'b1;

    cyc(); // c14
    check("flush_valid", {31'd0, valid_d}, 0);
    check("flush_instr", instr_d, 32'h13);
    check("flush_pc", pc_d, 0);
    stall_f = 1'b0;
    flush_d = 1'b0;

    cyc(); // c15
    check("c15_addr", imem_addr, 32'h108);
    check("c15_pc", pc_d, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;

    cyc(); // c16
    check("c16_valid", {31'd0, valid_d}, 0);
    check("c16_req", {31'd0, imem_req}, 0);
    redirect_valid = 1'b0;

    cyc(); // c17
    check("c17_req", {31'd0, imem_req}, 1);
    check("align_addr", imem_addr, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;

    cyc(); // c18
    check("c18_req", {31'd0, imem_req}, 0);
    redirect_valid = 1'b0;

    cyc(); // c19
    check("top_addr", imem_addr, 32'hFFFF_FFFC);

    cyc(); // c20
    check("c20_req", {31'd0, imem_req}, 0);

    cyc(); // c21
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", pc_d, 32'hFFFF_FFFC);
    check("wrap_pc4", pcplus4_d, 32'h0);
    check("wrap_valid", {31'd0, valid_d}, 1);
    memLat = 2;

    cyc(); // c22
    check("c22_req", {31'd0, imem_req}, 0);
    reset = 1'b1;
    memLat = 1;

    cyc(); // c23
    check("mrst_req", {31'd0, imem_req}, 0);
    check("mrst_valid", {31'd0, valid_d}, 0);
    reset = 1'b0;
    #1;
    check("mrst_req1", {31'd0, imem_req}, 1);
    check("mrst_addr", imem_addr, 32'h0);

    cyc(); // c24
    check("c24_req", {31'd0, imem_req}, 0);

    cyc(); // c25
    check("c25_valid", {31'd0, valid_d}, 1);
    check("c25_pc", pc_d, 32'h0);
    check("c25_instr", instr_d, instrOf(32'h0));
    check("c25_addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
